// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch unit
package fetch_unit_pkg;

  localparam int FETCH_WIDTH     = 4;
  localparam int INST_BUFF_DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } INST_PACKET;

  // One in-flight memory request: group address, first useful slot, path epoch
  typedef struct packed {
    logic [27:0] addr;
    logic [1:0]  offset;
    logic        epoch;
  } FETCH_REQ;

endpackage

// File: rtl/fetch_req_queue.sv
// rtl/fetch_req_queue.sv - in-order FIFO of outstanding fetch requests
module fetch_req_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, at least 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  FETCH_REQ                   push_data,
  input  logic                       pop,
  output FETCH_REQ                   pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  FETCH_REQ        slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = slots[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Entry storage needs no reset; only slots below count are ever read
  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

  // A response with nothing outstanding means memory and fetch disagree
  assert property (@(posedge clock) disable iff (!reset) pop |-> !empty);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch feeding the instruction buffer
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH           = INST_BUFF_DEPTH,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           br_en,
  input  logic [31:0]                    br_target,
  input  logic [$clog2(DEPTH+1)-1:0]     open_entries,
  output logic                           mem_req_valid,
  output logic [31:0]                    mem_req_addr,
  input  logic                           mem_req_ready,
  input  logic                           mem_resp_valid,
  input  logic [127:0]                   mem_resp_data,
  output INST_PACKET [FETCH_WIDTH-1:0]   out_insts,
  output logic [2:0]                     num_accept
);

  localparam int LW = $clog2(MAX_OUTSTANDING + 2);

  logic [31:0]                          pc;
  logic                                 epoch;
  logic [LW-1:0]                        live_cnt;
  logic                                 fire;
  logic                                 presenting;
  logic                                 resp_live;
  logic                                 q_full;
  logic                                 q_empty;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] unused_q_count;
  logic                                 unused_pc_bits;
  logic [31:0]                          need_slots;
  FETCH_REQ                             head;
  FETCH_REQ                             push_req;
  INST_PACKET [FETCH_WIDTH-1:0]         pack;
  logic [2:0]                           pack_cnt;

  // Four buffer slots are held back for every group still in flight
  assign need_slots     = (32'(live_cnt) + 32'd1) << 2;
  assign mem_req_valid  = reset & ~br_en & ~q_full & (32'(open_entries) >= need_slots);
  assign mem_req_addr   = {pc[31:4], 4'b0};
  assign fire           = mem_req_valid & mem_req_ready;
  assign presenting     = (num_accept != 3'd0);
  assign resp_live      = mem_resp_valid & ~br_en & ~q_empty & (head.epoch == epoch);
  assign push_req       = '{addr: pc[31:4], offset: pc[3:2], epoch: epoch};
  assign unused_pc_bits = ^pc[1:0];

  fetch_req_queue #(.DEPTH(MAX_OUTSTANDING)) u_req_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (fire),
    .push_data (push_req),
    .pop       (mem_resp_valid),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (unused_q_count)
  );

  // Shift the returned group down so the first useful slot lands in lane 0
  always_comb begin
    pack     = '0;
    pack_cnt = 3'd4 - {1'b0, head.offset};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if ((i + int'(head.offset)) < FETCH_WIDTH) begin
        pack[i].inst  = mem_resp_data[{2'(i) + head.offset, 5'b0} +: 32];
        pack[i].PC    = {head.addr, 4'b0} + 32'(4 * (i + int'(head.offset)));
        pack[i].NPC   = pack[i].PC + 32'd4;
        pack[i].valid = 1'b1;
      end
    end
  end

  // PC, epoch and live-group accounting; a redirect overrides everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      epoch    <= 1'b0;
      live_cnt <= '0;
    end else if (br_en) begin
      pc       <= br_target;
      epoch    <= ~epoch;
      live_cnt <= '0;
    end else begin
      if (fire) pc <= {pc[31:4] + 28'd1, 4'b0};
      if (fire && !presenting)      live_cnt <= live_cnt + LW'(1);
      else if (!fire && presenting) live_cnt <= live_cnt - LW'(1);
    end
  end

  // Output register holds a group for exactly one cycle, then clears
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_insts  <= '0;
      num_accept <= 3'd0;
    end else if (resp_live) begin
      out_insts  <= pack;
      num_accept <= pack_cnt;
    end else begin
      out_insts  <= '0;
      num_accept <= 3'd0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         br_en = 1'b0;
  logic [31:0]  br_target = '0;
  logic [4:0]   open_entries = '0;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;
  INST_PACKET [3:0] out_insts;
  logic [2:0]   num_accept;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .br_en          (br_en),
    .br_target      (br_target),
    .open_entries   (open_entries),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_insts      (out_insts),
    .num_accept     (num_accept)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    int          gen;
  } req_t;

  req_t             m_q[$];
  logic [31:0]      m_pc;
  int               m_gen;
  INST_PACKET [3:0] m_out;
  int               m_num;
  logic             exp_valid;
  logic [31:0]      exp_addr;

  logic        d_br;
  logic        d_ready;
  logic        d_resp;
  logic [31:0] d_tgt;
  int          d_open;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int live_groups();
    int n = (m_num != 0) ? 1 : 0;
    foreach (m_q[i]) if (m_q[i].gen == m_gen) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc  = 32'h0;
    m_gen = 0;
    m_out = '0;
    m_num = 0;
    d_br = 1'b0; d_ready = 1'b0; d_resp = 1'b0; d_tgt = '0; d_open = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    br_en = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; open_entries = '0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Drive this cycle's inputs, act as memory, predict outputs, go to negedge
  task automatic apply();
    br_en          = d_br;
    br_target      = d_tgt;
    open_entries   = 5'(d_open);
    mem_req_ready  = d_ready;
    mem_resp_valid = d_resp && (m_q.size() > 0);
    mem_resp_data  = '0;
    if (mem_resp_valid)
      for (int k = 0; k < 4; k++)
        mem_resp_data[32*k +: 32] = inst_of({m_q[0].pc[31:4], 4'b0} + 32'(4 * k));
    exp_valid = reset && !d_br && (m_q.size() < 4) && (d_open >= 4 * (live_groups() + 1));
    exp_addr  = {m_pc[31:4], 4'b0};
    @(negedge clock);
  endtask

  // Reference model update at the clock edge
  task automatic advance();
    logic             fire;
    req_t             h;
    INST_PACKET [3:0] nxt;
    int               nn;
    fire = exp_valid && d_ready;
    nxt  = '0;
    nn   = 0;
    if (mem_resp_valid) begin
      h = m_q.pop_front();
      if (!d_br && h.gen == m_gen) begin
        nn = 4 - int'(h.pc[3:2]);
        for (int i = 0; i < nn; i++) begin
          nxt[i].PC    = h.pc + 32'(4 * i);
          nxt[i].NPC   = nxt[i].PC + 32'd4;
          nxt[i].inst  = inst_of(nxt[i].PC);
          nxt[i].valid = 1'b1;
        end
      end
    end
    if (d_br) begin
      m_pc  = d_tgt;
      m_gen = m_gen + 1;
    end else if (fire) begin
      m_q.push_back('{pc: m_pc, gen: m_gen});
      m_pc = {m_pc[31:4] + 28'd1, 4'b0};
    end
    m_out = nxt;
    m_num = nn;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    d_open = 16; d_ready = 1'b1;
    apply();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b want=0", mem_req_valid); end
    checks++; if (num_accept !== 3'd0) begin errors++; $display("FAIL reset_num_accept got=%0d want=0", num_accept); end
    checks++; if (out_insts !== '0) begin errors++; $display("FAIL reset_out_insts got=%h want=0", out_insts); end
    @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_startup();
    do_reset();
    d_open = 16; d_ready = 1'b1; d_resp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'(16 * c)) begin
        errors++; $display("FAIL startup_req c=%0d got=%b/%h want=1/%h", c, mem_req_valid, mem_req_addr, 32'(16 * c)); end
      if (c < 2) begin
        checks++; if (num_accept !== 3'd0) begin errors++; $display("FAIL startup_early_accept c=%0d got=%0d want=0", c, num_accept); end
      end else begin
        checks++; if (num_accept !== 3'd4) begin errors++; $display("FAIL startup_num c=%0d got=%0d want=4", c, num_accept); end
        checks++; if (out_insts[0].PC !== 32'(16 * (c - 2)) || out_insts[3].PC !== 32'(16 * (c - 2) + 12)) begin
          errors++; $display("FAIL startup_pc c=%0d got=%h/%h", c, out_insts[0].PC, out_insts[3].PC); end
      end
      if (c == 2) begin
        checks++; if (out_insts[3].NPC !== 32'h10 || out_insts[2].inst !== inst_of(32'h8) || out_insts[1].valid !== 1'b1) begin
          errors++; $display("FAIL startup_group got npc=%h inst=%h want npc=10 inst=%h", out_insts[3].NPC, out_insts[2].inst, inst_of(32'h8)); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    do_reset();
    d_open = 16; d_ready = 1'b1; d_resp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      apply();
      checks++; if (mem_req_valid !== (c < 4) || (c < 4 && mem_req_addr !== 32'(16 * c))) begin
        errors++; $display("FAIL stall_req c=%0d got=%b/%h want=%b/%h", c, mem_req_valid, mem_req_addr, c < 4, 32'(16 * c)); end
      advance();
    end
    d_open = 0; d_resp = 1'b1;
    for (int c = 0; c < 6; c++) begin
      apply();
      checks++; if (num_accept !== 3'(m_num) || out_insts !== m_out) begin
        errors++; $display("FAIL stall_drain c=%0d got=%0d want=%0d", c, num_accept, m_num); end
      advance();
    end
  endtask

  task automatic test_open_gate();
    do_reset();
    d_open = 4; d_ready = 1'b1; d_resp = 1'b0;
    apply();
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL open4_live0 got=%b want=1", mem_req_valid); end
    advance();
    d_open = 7;
    apply();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL open7_live1 got=%b want=0", mem_req_valid); end
    advance();
    d_open = 8;
    apply();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h10) begin
      errors++; $display("FAIL open8_live1 got=%b/%h want=1/00000010", mem_req_valid, mem_req_addr); end
    advance();
  endtask

  task automatic test_branch();
    do_reset();
    d_open = 16; d_ready = 1'b1; d_resp = 1'b0;
    repeat (3) begin apply(); advance(); end
    d_br = 1'b1; d_tgt = 32'h10C;
    apply();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL br_req_valid got=%b want=0", mem_req_valid); end
    advance();
    d_br = 1'b0; d_ready = 1'b0; d_resp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply();
      checks++; if (num_accept !== 3'd0) begin errors++; $display("FAIL br_stale_drop c=%0d got=%0d want=0", c, num_accept); end
      advance();
    end
    d_ready = 1'b1; d_resp = 1'b0;
    apply();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
      errors++; $display("FAIL br_new_req got=%b/%h want=1/00000100", mem_req_valid, mem_req_addr); end
    advance();
    d_resp = 1'b1;
    apply();
    checks++; if (mem_req_addr !== 32'h110) begin errors++; $display("FAIL br_next_req got=%h want=00000110", mem_req_addr); end
    advance();
    d_ready = 1'b0;
    apply();
    checks++; if (num_accept !== 3'd1 || out_insts[0].PC !== 32'h10C || out_insts[0].NPC !== 32'h110
                  || out_insts[0].inst !== inst_of(32'h10C) || out_insts[1] !== '0) begin
      errors++; $display("FAIL br_unaligned got num=%0d pc=%h npc=%h want 1/0000010c/00000110", num_accept, out_insts[0].PC, out_insts[0].NPC); end
    advance();
    apply();
    checks++; if (num_accept !== 3'd4 || out_insts[0].PC !== 32'h110) begin
      errors++; $display("FAIL br_aligned got num=%0d pc=%h want 4/00000110", num_accept, out_insts[0].PC); end
    advance();
  endtask

  task automatic test_br_collide();
    do_reset();
    d_open = 16; d_ready = 1'b1; d_resp = 1'b0;
    apply(); advance();
    d_br = 1'b1; d_tgt = 32'h40; d_resp = 1'b1;
    apply();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL collide_req got=%b want=0", mem_req_valid); end
    advance();
    d_br = 1'b0; d_ready = 1'b0; d_resp = 1'b0;
    apply();
    checks++; if (num_accept !== 3'd0) begin errors++; $display("FAIL collide_drop got=%0d want=0", num_accept); end
    advance();
  endtask

  task automatic test_ready_stall();
    do_reset();
    d_open = 16; d_ready = 1'b0; d_resp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      apply();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
        errors++; $display("FAIL ready_hold c=%0d got=%b/%h want=1/00000000", c, mem_req_valid, mem_req_addr); end
      advance();
    end
    d_ready = 1'b1;
    apply(); advance();
    d_ready = 1'b0;
    apply();
    checks++; if (mem_req_addr !== 32'h10) begin errors++; $display("FAIL ready_single_fire got=%h want=00000010", mem_req_addr); end
    advance();
  endtask

  task automatic test_async_reset();
    do_reset();
    d_open = 16; d_ready = 1'b1; d_resp = 1'b0;
    repeat (3) begin apply(); advance(); end
    d_ready = 1'b0; d_resp = 1'b1;
    apply(); advance();
    d_resp = 1'b0;
    apply();
    checks++; if (num_accept !== 3'd4) begin errors++; $display("FAIL areset_pre got=%0d want=4", num_accept); end
    #1 reset = 1'b0;
    #1;
    checks++; if (num_accept !== 3'd0 || out_insts !== '0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL areset_immediate got num=%0d valid=%b want 0/0", num_accept, mem_req_valid); end
    mem_resp_valid = 1'b0;
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    d_open = 16; d_ready = 1'b1;
    apply();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
      errors++; $display("FAIL areset_restart got=%b/%h want=1/00000000", mem_req_valid, mem_req_addr); end
    advance();
  endtask

  task automatic test_random();
    logic can_br;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      can_br = 1'b1;
      foreach (m_q[i]) if (m_q[i].gen != m_gen) can_br = 1'b0;
      d_br    = can_br && ($urandom_range(15, 0) == 0);
      d_tgt   = ($urandom_range(5, 0) == 0) ? 32'hFFFF_FFE4 - 32'(4 * $urandom_range(3, 0))
                                             : {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      d_open  = ($urandom_range(1, 0) == 0) ? $urandom_range(16, 0) : $urandom_range(16, 8);
      d_ready = ($urandom_range(3, 0) != 0);
      d_resp  = ($urandom_range(1, 0) == 0);
      apply();
      checks++; if (mem_req_valid !== exp_valid) begin
        errors++; $display("FAIL rand_req_valid c=%0d got=%b want=%b", c, mem_req_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (mem_req_addr !== exp_addr) begin
          errors++; $display("FAIL rand_req_addr c=%0d got=%h want=%h", c, mem_req_addr, exp_addr); end
      end
      checks++; if (num_accept !== 3'(m_num)) begin
        errors++; $display("FAIL rand_num_accept c=%0d got=%0d want=%0d", c, num_accept, m_num); end
      checks++; if (out_insts !== m_out) begin
        errors++; $display("FAIL rand_out_insts c=%0d got=%h want=%h", c, out_insts, m_out); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_open_gate();
    test_branch();
    test_br_collide();
    test_ready_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Producer feeding the instruction buffer's write side: generates sequential fetch requests to instruction memory and packs returned 4-instruction groups into INST_PACKETs.
- Drives in_insts and num_accept into the buffer. Never overruns the buffer's open_entries.
- On branch squash (br_en), redirects to br_target and discards all in-flight responses from the old path.

Parameters:
- DEPTH, `INST_BUFF_DEPTH: buffer depth; sizes open_entries.
- MAX_OUTSTANDING, 4: max issued-but-unreturned memory requests (power of 2).
- RESET_PC, 32'h0: PC loaded at reset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- br_en  in  1  squash/redirect, one-cycle pulse
- br_target  in  32  redirect PC, word aligned
- open_entries  in  $clog2(DEPTH+1)  free buffer slots this cycle, from inst_buffer
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  32  16-byte aligned group address
- mem_req_ready  in  1  memory accepts request; fire = valid & ready
- mem_resp_valid  in  1  response valid; responses return strictly in request order
- mem_resp_data  in  128  four 32-bit instructions; slot k = bits [32k+31:32k]
- out_insts  out  INST_PACKET[3:0]  packed group to buffer (in_insts)
- num_accept  out  3  valid count in out_insts, 0..4

Behaviour:
- Reset (async assert, sync-safe deassert): pc=RESET_PC, epoch=0, live_cnt=0, queue empty, out_insts='0, num_accept=0, mem_req_valid=0.
- Request queue: FIFO of {group_addr[31:4], offset[1:0], epoch}, depth MAX_OUTSTANDING. Push on fire; pop on mem_resp_valid. A response with an empty queue is a protocol error; assert in simulation.
- live_cnt: groups issued in current epoch and not yet presented to the buffer, including the group held in the output register.
- mem_req_valid = !br_en & !queue_full & (open_entries >= 4*(live_cnt+1)). This reserves 4 slots per live group, so no overrun is possible.
- mem_req_addr = {pc[31:4],4'b0}. Pushed offset = pc[3:2].
- On fire: pc <= {pc[31:4]+1, 4'b0}, live_cnt++.
- Response (pop): if entry.epoch == epoch and !br_en, load the output register:
  - slots offset..3 -> out_insts[0..3-offset]
  - out_insts[i].PC = {addr,4'b0} + 4*(offset+i); NPC = PC+4; valid = 1
  - unused slots = '0; num_accept = 4-offset
  - otherwise discard.
- Output register is presented for exactly one cycle, then cleared. live_cnt decrements at the end of the presenting cycle. Latency: response cycle N -> num_accept nonzero in cycle N+1.
- Simultaneous fire and present: live_cnt unchanged.
- br_en (takes priority over everything):
  - pc <= br_target; epoch <= ~epoch; live_cnt <= 0; output register cleared (num_accept=0 next cycle).
  - mem_req_valid forced 0 this cycle; queue entries stay and drain as stale.
  - A response arriving in the br_en cycle is dropped.
  - Any num_accept presented in the br_en cycle is ignored by the buffer, which is flushing.
- Redirect to an unaligned target (e.g. PC[3:2]=3): first group yields 1 instruction; following groups are aligned and yield 4.
- PC wrap 32'hFFFF_FFF0 -> 32'h0 is modulo 2^32; no special handling.
- Queue pointers wrap modulo MAX_OUTSTANDING; full = count==MAX_OUTSTANDING.

Decomposition:
- Shared package / sys_defs.svh holds:
  - INST_PACKET (inst, PC, NPC, valid)
  - `FETCH_WIDTH=4
  - FETCH_REQ typedef {addr[27:0], offset[1:0], epoch}
- One sub-module: fetch_req_queue. Parameterised in-order FIFO of FETCH_REQ with push, pop, full, empty, and count outputs.
- Packing and PC generation stay in fetch_unit.

Test Plan:
- Reset, open_entries=16, memory ready, 1-cycle latency -> requests at 0x0, 0x10, 0x20, 0x30, then stall at live_cnt=4. First num_accept=4 with PCs 0x0..0xC appears 2 cycles after the first request.
- open_entries=7, live_cnt=1 -> mem_req_valid=0. Raise open_entries to 8 -> request issues the same cycle.
- br_en with br_target=0x10C while 3 requests are outstanding:
  - 3 stale responses are dropped (num_accept stays 0).
  - Next request addr=0x100; its group gives num_accept=1, PC=0x10C, NPC=0x110.
  - Following group starts at PC 0x110.
- br_en in the same cycle as mem_resp_valid and as a would-be fire -> no request, response dropped, num_accept=0 next cycle.
- mem_req_ready held 0 for 5 cycles -> mem_req_addr stable, pc unchanged. Ready=1 -> a single fire at that address.
- Assert reset mid-stream with 2 outstanding and a presented group -> outputs are 0 immediately (asynchronous). After release, fetch restarts at RESET_PC; late responses trip the empty-queue assertion unless memory is also reset.
